// File: rtl/cla_adder_16.sv
// 16-bit two-level carry-lookahead adder with a combinational sum and a one-cycle registered copy.
// Optional signed-overflow outputs ovf/ovf_r are built when CLA_OVF_EN is defined.
module cla_adder_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        cin,
  output logic [15:0] S,
  output logic        cout,
  output logic [15:0] S_r,
  output logic        cout_r
`ifdef CLA_OVF_EN
  ,
  output logic        ovf,
  output logic        ovf_r
`endif
);

  // Group generate/propagate for one 4-bit group: {GG, GP}.
  function automatic logic [1:0] grp_gen_prop(input logic [3:0] g, input logic [3:0] p);
    logic gg;
    logic gp;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp = p[3] & p[2] & p[1] & p[0];
    return {gg, gp};
  endfunction

  // Internal carries of one group, each expanded directly from the group carry-in: {c3, c2, c1}.
  function automatic logic [2:0] grp_carries(input logic [3:0] g, input logic [3:0] p,
                                             input logic ci);
    logic c1;
    logic c2;
    logic c3;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return {c3, c2, c1};
  endfunction

  logic [15:0] gen_s;
  logic [15:0] prop_s;
  logic [3:0]  gg_s;
  logic [3:0]  gp_s;
  logic [4:0]  grp_c_s;
  logic [15:0] int_c_s;
  logic [15:0] sum_s;
  logic        c16_s;

  assign gen_s  = A & B;
  assign prop_s = A ^ B;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign {gg_s[k], gp_s[k]} = grp_gen_prop(gen_s[4*k+3 -: 4], prop_s[4*k+3 -: 4]);
    assign int_c_s[4*k+3 -: 4] =
      {grp_carries(gen_s[4*k+3 -: 4], prop_s[4*k+3 -: 4], grp_c_s[k]), grp_c_s[k]};
  end

  // Second-level lookahead: every group carry is a flat sum of products of GG/GP and cin.
  always_comb begin
    grp_c_s    = 5'b00000;
    grp_c_s[0] = cin;
    grp_c_s[1] = gg_s[0] | (gp_s[0] & cin);
    grp_c_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & cin);
    grp_c_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
               | (gp_s[2] & gp_s[1] & gp_s[0] & cin);
    grp_c_s[4] = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
               | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
               | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & cin);
  end

  assign sum_s = prop_s ^ int_c_s;
  assign c16_s = grp_c_s[4];
  assign S     = sum_s;
  assign cout  = c16_s;

  logic [15:0] s_d;
  logic [15:0] s_q;
  logic        cout_d;
  logic        cout_q;

  assign s_d    = sum_s;
  assign cout_d = c16_s;

  // Output register stage, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= 16'h0000;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign S_r    = s_q;
  assign cout_r = cout_q;

`ifdef CLA_OVF_EN
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = c16_s ^ int_c_s[15];
  assign ovf   = ovf_d;

  // Registered overflow flag, same reset behaviour as cout_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_r = ovf_q;
`endif

endmodule

// File: tb/tb_cla_adder_16.sv
// Self-checking bench for cla_adder_16: directed corners, random vectors and async reset.
module tb_cla_adder_16;
  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic        cin;
  logic [15:0] S;
  logic        cout;
  logic [15:0] S_r;
  logic        cout_r;
`ifdef CLA_OVF_EN
  logic        ovf;
  logic        ovf_r;
`endif

  int n_total = 0;
  int n_bad   = 0;

  cla_adder_16 dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .cin(cin),
    .S(S), .cout(cout), .S_r(S_r), .cout_r(cout_r)
`ifdef CLA_OVF_EN
    , .ovf(ovf), .ovf_r(ovf_r)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                          input logic c);
    int unsigned t;
    t = int'(a) + int'(b) + int'(c);
    return t[16:0];
  endfunction

  function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b, input logic c);
    int t;
    t = int'($signed(a)) + int'($signed(b)) + int'(c);
    return (t > 32767) || (t < -32768);
  endfunction

  // Apply a vector away from the edge, check comb outputs, then the registered copy after the edge.
  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c);
    logic [16:0] e;
    @(negedge clk);
    A = a; B = b; cin = c;
    #1;
    e = ref_sum(a, b, c);
    check({tag, "_comb"}, {15'h0, cout, S}, {15'h0, e});
`ifdef CLA_OVF_EN
    check({tag, "_ovf"}, {31'h0, ovf}, {31'h0, ref_ovf(a, b, c)});
`endif
    @(posedge clk);
    #1;
    check({tag, "_reg"}, {15'h0, cout_r, S_r}, {15'h0, e});
`ifdef CLA_OVF_EN
    check({tag, "_ovf_r"}, {31'h0, ovf_r}, {31'h0, ref_ovf(a, b, c)});
`endif
  endtask

  logic [15:0] da [8];
  logic [15:0] db [8];
  logic        dc [8];

  initial begin
    rst_n = 1'b0; A = 16'h0000; B = 16'h0000; cin = 1'b0;
    da = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000, 16'hAAAA};
    db = '{16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 16'h8000, 16'h0001, 16'h0000, 16'h5555};
    dc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    #12;
    check("rst_reg", {15'h0, cout_r, S_r}, 32'h0);
    check("rst_comb", {15'h0, cout, S}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) apply($sformatf("dir%0d", i), da[i], db[i], dc[i]);
    for (int i = 0; i < 120; i++)
      apply($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom), 1'($urandom));

    apply("pre_rst", 16'h1234, 16'h0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clr", {15'h0, cout_r, S_r}, 32'h0);
    A = 16'h0005; B = 16'h0003; cin = 1'b0;
    #1;
    check("comb_in_rst", {15'h0, cout, S}, 32'h0008);
    @(posedge clk);
    #1;
    check("held_in_rst", {15'h0, cout_r, S_r}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("held_after_rel", {15'h0, cout_r, S_r}, 32'h0);
    @(posedge clk);
    #1;
    check("first_load", {15'h0, cout_r, S_r}, 32'h0008);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/cla_adder_16.md
Name: cla_adder_16

Overview:
- 16-bit two-level carry-lookahead adder: S = A + B + cin, with carry-out.
- Primary outputs S/cout are purely combinational.
- A registered copy (S_r/cout_r) is provided for pipelined datapaths, e.g. ALU/address adders that need a timing break.
- Carry chain is hierarchical lookahead, not ripple.

Parameters:
- none: width is fixed at 16 bits, organised as four 4-bit groups.

Ports:
- clk     input   1   rising-edge clock, used only by the output register stage
- rst_n   input   1   asynchronous active-low reset, clears the output register stage
- A       input   16  addend A, unsigned or two's complement
- B       input   16  addend B
- cin     input   1   carry-in
- S       output  16  combinational sum bits [15:0] of A+B+cin
- cout    output  1   combinational carry-out, bit 16 of A+B+cin
- S_r     output  16  S registered on rising clk
- cout_r  output  1   cout registered on rising clk

Behaviour:
- Arithmetic: {cout,S} == A + B + cin, evaluated as a 17-bit unsigned sum; must hold for all 2^33 input combinations.
- Bit level: per-bit g[i]=A[i]&B[i], p[i]=A[i]^B[i]; S[i]=p[i]^c[i]; c[0]=cin.
- Level 1: four 4-bit CLA groups (bits 3:0, 7:4, 11:8, 15:12).
  - Each group computes its internal carries from g/p and the group carry-in, with no ripple inside the group.
  - Each group outputs group generate GG and group propagate GP, where GP = AND of its p bits and GG = standard lookahead expansion.
- Level 2: lookahead carry unit computes c4, c8, c12 and c16 directly from GG/GP[3:0] and cin, using fully expanded sum-of-products terms; cout = c16.
  - No carry may pass group-to-group serially.
- Combinational path:
  - S/cout respond to A/B/cin within one combinational settle.
  - They are independent of clk and rst_n, including while rst_n is low.
- Register stage:
  - On each rising clk with rst_n high: S_r<=S, cout_r<=cout. Latency is 1 cycle.
  - No enable; the register loads every cycle.
- Reset:
  - rst_n low asynchronously forces S_r=16'h0000 and cout_r=0 immediately, independent of clk.
  - Values are held until the first rising clk after rst_n returns high.
  - Reset asserted mid-stream discards the pending registered value; the combinational outputs are unaffected.
- Boundaries:
  - All-ones + 1 wraps S to 0 with cout=1.
  - cin=1 with A=B=0 gives S=1.
  - Propagate-only chains (A^B=FFFF) with cin=1 must carry through all four groups via GP terms.
- No X propagation: with all inputs known, all outputs are known.

Optional Feature:
- Macro CLA_OVF_EN.
- Defined: adds output ovf (1 bit, combinational) = c16 ^ c15, the signed two's-complement overflow. Also adds ovf_r (1 bit), registered with the same clk/rst_n rules as cout_r and reset to 0.
- Not defined: ovf and ovf_r ports are absent; all other behaviour is identical.

Test Plan:
- Zero case: A=0000, B=0000, cin=0 -> S=0000, cout=0; next clk S_r=0000, cout_r=0.
- Wrap: A=FFFF, B=0001, cin=0 -> S=0000, cout=1. Propagate chain: A=FFFF, B=0000, cin=1 -> S=0000, cout=1.
- Max sum: A=FFFF, B=FFFF, cin=1 -> S=FFFF, cout=1. Signed overflow: A=8000, B=8000, cin=0 -> S=0000, cout=1, ovf=1 (with CLA_OVF_EN). A=7FFF, B=0001 -> S=8000, cout=0, ovf=1.
- Random regression: 100+ vectors of random A/B/cin, settle, then compare {cout,S} against A+B+cin using case inequality; any mismatch fails. S_r/cout_r must equal the previous cycle's S/cout.
- Reset: with S_r=1234 loaded, drop rst_n between clock edges -> S_r=0000, cout_r=0 immediately, while S/cout keep tracking inputs. Release rst_n -> the first rising clk loads the current sum.
